// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the ASIP front-end pipeline sequencer.
package rsa_pipe_pkg;

  localparam int MEM_ADDR_W = 13;
  localparam int REG_W      = 4;

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_MC_WAIT = 3'd3,
    ST_HALT    = 3'd4,
    ST_ERROR   = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID sources and the EX load destination.
module hazard_detect
  import rsa_pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  // A load into the hardwired-zero register never produces a hazard.
  assign load_use = ex_is_load && (ex_rd != REG_ZERO) &&
                    ((id_rs1 == ex_rd) || (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Front-end sequencer: PC enable, branch redirect, IF/ID stall/flush, MC waits,
// halt/resume, MC timeout trap and a saturating stall-cycle counter.
module pipeline_ctrl
  import rsa_pipe_pkg::*;
#(
  parameter int MEM_ADDR     = MEM_ADDR_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                halt_req,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_uses_rs2,
  input  logic                ex_is_load,
  input  logic [REG_W-1:0]    ex_rd,
  input  logic                ex_branch_taken,
  input  logic [MEM_ADDR-1:0] ex_branch_target,
  input  logic                mc_start,
  input  logic                mc_done,
  output logic                pc_enable,
  output logic                branch_taken,
  output logic [MEM_ADDR-1:0] jump_address,
  output logic                ifid_stall,
  output logic                ifid_flush,
  output logic                idex_bubble,
  output logic                mc_timeout,
  output logic [2:0]          state_o,
  output logic [15:0]         stall_cycles
);

  localparam bit         FLUSH_SINGLE = (FLUSH_CYCLES <= 1);
  localparam logic [7:0] FLUSH_RELOAD = 8'(FLUSH_CYCLES - 1);
  localparam logic [8:0] MC_LIMIT     = 9'(MC_TIMEOUT);

  ctrl_state_e state_q, state_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  mc_cnt_q, mc_cnt_d;
  logic [15:0] stall_q, stall_d;

  logic                load_use_s;
  logic                pc_en_s, bt_s, stall_s, flush_s, bubble_s, timeout_s;
  logic [MEM_ADDR-1:0] ja_s;
  logic [8:0]          mc_next_s;

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .load_use    (load_use_s)
  );

  assign mc_next_s = {1'b0, mc_cnt_q} + 9'd1;

  // Next-state, counter and raw control-output decode.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    mc_cnt_d    = mc_cnt_q;
    pc_en_s     = 1'b0;
    bt_s        = 1'b0;
    ja_s        = {MEM_ADDR{1'b0}};
    stall_s     = 1'b0;
    flush_s     = 1'b0;
    bubble_s    = 1'b0;
    timeout_s   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        flush_s = 1'b1;
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        pc_en_s = 1'b1;
        if (ex_branch_taken) begin
          bt_s        = 1'b1;
          ja_s        = ex_branch_target;
          flush_s     = 1'b1;
          bubble_s    = 1'b1;
          flush_cnt_d = FLUSH_RELOAD;
          state_d     = FLUSH_SINGLE ? ST_RUN : ST_FLUSH;
        end else if (mc_start) begin
          pc_en_s  = 1'b0;
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          mc_cnt_d = 8'd0;
          state_d  = ST_MC_WAIT;
        end else if (load_use_s) begin
          pc_en_s  = 1'b0;
          stall_s  = 1'b1;
          bubble_s = 1'b1;
        end else if (halt_req) begin
          pc_en_s = 1'b0;
          flush_s = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        pc_en_s  = 1'b1;
        flush_s  = 1'b1;
        bubble_s = 1'b1;
        // A branch resolving during the flush window redirects and restarts it.
        if (ex_branch_taken) begin
          bt_s        = 1'b1;
          ja_s        = ex_branch_target;
          flush_cnt_d = FLUSH_RELOAD;
          state_d     = FLUSH_SINGLE ? ST_RUN : ST_FLUSH;
        end else if (flush_cnt_q <= 8'd1) begin
          flush_cnt_d = 8'd0;
          state_d     = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 8'd1;
        end
      end
      ST_MC_WAIT: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
        if (mc_done) begin
          mc_cnt_d = 8'd0;
          state_d  = ST_RUN;
        end else if (mc_next_s >= MC_LIMIT) begin
          mc_cnt_d = mc_next_s[7:0];
          state_d  = ST_ERROR;
        end else begin
          mc_cnt_d = mc_next_s[7:0];
        end
      end
      ST_ERROR: begin
        flush_s   = 1'b1;
        timeout_s = 1'b1;
      end
      default: begin
        flush_s = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stall counter saturates; only cycles where the front end could have fetched count.
  always_comb begin
    stall_d = stall_q;
    if (!pc_en_s && ((state_q == ST_RUN) || (state_q == ST_MC_WAIT)) &&
        (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 8'd0;
      mc_cnt_q    <= 8'd0;
      stall_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign pc_enable    = pc_en_s & ~rst;
  assign branch_taken = bt_s & ~rst;
  assign jump_address = rst ? {MEM_ADDR{1'b0}} : ja_s;
  assign ifid_stall   = stall_s & ~rst;
  assign ifid_flush   = flush_s | rst;
  assign idex_bubble  = bubble_s & ~rst;
  assign mc_timeout   = timeout_s & ~rst;
  assign state_o      = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a cycle-level behavioural reference model.
module tb_pipeline_ctrl;
  import rsa_pipe_pkg::*;

  localparam int FC = 2;
  localparam int MT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, halt_req = 1'b0, id_uses_rs2 = 1'b0, ex_is_load = 1'b0;
  logic [3:0]  id_rs1 = 4'd0, id_rs2 = 4'd0, ex_rd = 4'd0;
  logic        ex_branch_taken = 1'b0, mc_start = 1'b0, mc_done = 1'b0;
  logic [12:0] ex_branch_target = 13'd0;
  logic        pc_enable, branch_taken, ifid_stall, ifid_flush, idex_bubble, mc_timeout;
  logic [12:0] jump_address;
  logic [2:0]  state_o;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_ADDR(13), .FLUSH_CYCLES(FC), .MC_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .mc_start(mc_start), .mc_done(mc_done),
    .pc_enable(pc_enable), .branch_taken(branch_taken), .jump_address(jump_address),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .mc_timeout(mc_timeout), .state_o(state_o), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0..5 mirrors state_o; flush_left = flush cycles still owed,
  // waited = MC cycles already spent, stalls = counted stall cycles.
  int   m_mode = 0, m_flush_left = 0, m_waited = 0, m_stalls = 0;
  int   nx_mode = 0, nx_flush_left = 0, nx_waited = 0, nx_stalls = 0;
  logic e_pc, e_bt, e_st, e_fl, e_bub, e_to, lu;
  logic [12:0] e_ja;
  logic [63:0] exp_v, act_v;

  always @(negedge clk) begin
    {e_pc, e_bt, e_st, e_fl, e_bub, e_to} = 6'b0;
    e_ja = 13'd0;
    nx_mode = m_mode; nx_flush_left = m_flush_left; nx_waited = m_waited; nx_stalls = m_stalls;
    lu = ex_is_load && (ex_rd != 4'd0) &&
         ((id_rs1 == ex_rd) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    if (rst) begin
      e_fl = 1'b1;
      nx_mode = 0; nx_flush_left = 0; nx_waited = 0; nx_stalls = 0;
    end else begin
      case (m_mode)
        0, 4: begin
          e_fl = 1'b1;
          if (start) nx_mode = 1;
        end
        1: begin
          e_pc = 1'b1;
          if (ex_branch_taken) begin
            e_bt = 1'b1; e_ja = ex_branch_target; e_fl = 1'b1; e_bub = 1'b1;
            nx_flush_left = FC - 1;
            nx_mode = (FC > 1) ? 2 : 1;
          end else if (mc_start) begin
            e_pc = 1'b0; e_st = 1'b1; e_bub = 1'b1; nx_mode = 3; nx_waited = 0;
          end else if (lu) begin
            e_pc = 1'b0; e_st = 1'b1; e_bub = 1'b1;
          end else if (halt_req) begin
            e_pc = 1'b0; e_fl = 1'b1; nx_mode = 4;
          end
        end
        2: begin
          e_pc = 1'b1; e_fl = 1'b1; e_bub = 1'b1;
          if (ex_branch_taken) begin
            e_bt = 1'b1; e_ja = ex_branch_target;
            nx_flush_left = FC - 1;
            nx_mode = (FC > 1) ? 2 : 1;
          end else begin
            nx_flush_left = m_flush_left - 1;
            if (nx_flush_left <= 0) nx_mode = 1;
          end
        end
        3: begin
          e_st = 1'b1; e_bub = 1'b1;
          if (mc_done) nx_mode = 1;
          else begin
            nx_waited = m_waited + 1;
            if (nx_waited >= MT) nx_mode = 5;
          end
        end
        default: begin
          e_fl = 1'b1; e_to = 1'b1;
        end
      endcase
      if ((m_mode == 1 || m_mode == 3) && !e_pc && m_stalls < 65535) nx_stalls = m_stalls + 1;
    end
    exp_v = {26'd0, e_pc, e_bt, e_ja, e_st, e_fl, e_bub, e_to,
             rst ? 3'd0 : 3'(m_mode), rst ? 16'd0 : 16'(m_stalls)};
    act_v = {26'd0, pc_enable, branch_taken, jump_address, ifid_stall, ifid_flush,
             idex_bubble, mc_timeout, state_o, stall_cycles};
    chk("cycle_model", act_v, exp_v);
  end

  always @(posedge clk) begin
    m_mode = nx_mode; m_flush_left = nx_flush_left; m_waited = nx_waited; m_stalls = nx_stalls;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("reset_state", 64'(state_o), 64'd0);
    chk("reset_flush", 64'(ifid_flush), 64'd1);
    chk("reset_pc", 64'(pc_enable), 64'd0);
    tick(); tick();
    rst = 1'b0;
    #1 chk("idle_pc", 64'(pc_enable), 64'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    #1;
    chk("run_state", 64'(state_o), 64'd1);
    chk("run_pc", 64'(pc_enable), 64'd1);
    chk("run_flush", 64'(ifid_flush), 64'd0);
    tick(); tick();

    ex_branch_taken = 1'b1; ex_branch_target = 13'h0A4;
    #1;
    chk("br_strobe", 64'(branch_taken), 64'd1);
    chk("br_addr", 64'(jump_address), 64'h0A4);
    chk("br_flush", 64'(ifid_flush), 64'd1);
    tick(); ex_branch_taken = 1'b0;
    #1;
    chk("flush_state", 64'(state_o), 64'd2);
    chk("flush_hold", 64'(ifid_flush), 64'd1);
    chk("flush_pc", 64'(pc_enable), 64'd1);
    tick();
    chk("flush_end", 64'(ifid_flush), 64'd0);
    ex_branch_taken = 1'b1; ex_branch_target = 13'h0A4;
    tick(); ex_branch_target = 13'h005;
    #1 chk("rebranch_addr", 64'(jump_address), 64'h005);
    tick(); ex_branch_taken = 1'b0;
    #1 chk("rebranch_flush", 64'(state_o), 64'd2);
    tick(); tick();

    ex_is_load = 1'b1; ex_rd = 4'd3; id_rs2 = 4'd3; id_uses_rs2 = 1'b1; id_rs1 = 4'd5;
    #1;
    chk("lu_pc", 64'(pc_enable), 64'd0);
    chk("lu_stall", 64'({ifid_stall, idex_bubble}), 64'd3);
    tick(); ex_rd = 4'd0; id_rs1 = 4'd0; id_rs2 = 4'd0;
    #1;
    chk("lu_count", 64'(stall_cycles), 64'd1);
    chk("lu_r0_pc", 64'(pc_enable), 64'd1);
    tick(); ex_rd = 4'd7; id_rs2 = 4'd7; id_uses_rs2 = 1'b0;
    #1 chk("lu_norsp2_pc", 64'(pc_enable), 64'd1);
    tick(); id_rs1 = 4'd7;
    #1 chk("lu_rs1_pc", 64'(pc_enable), 64'd0);
    tick(); ex_is_load = 1'b0;

    mc_start = 1'b1;
    #1 chk("mc_issue_pc", 64'(pc_enable), 64'd0);
    tick(); mc_start = 1'b0;
    chk("mc_state", 64'(state_o), 64'd3);
    repeat (3) @(posedge clk);
    tick(); mc_done = 1'b1;
    #1 chk("mc_last", 64'(state_o), 64'd3);
    tick(); mc_done = 1'b0;
    #1;
    chk("mc_resume", 64'(state_o), 64'd1);
    chk("mc_stalls", 64'(stall_cycles), 64'd8);

    halt_req = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 13'h1FFF;
    #1 chk("halt_br_addr", 64'(jump_address), 64'h1FFF);
    tick(); halt_req = 1'b0; ex_branch_taken = 1'b0;
    #1 chk("halt_squashed", 64'(state_o), 64'd2);
    tick(); tick();
    halt_req = 1'b1;
    #1 chk("halt_flush", 64'({pc_enable, ifid_flush}), 64'd1);
    tick(); halt_req = 1'b0;
    #1 chk("halt_state", 64'(state_o), 64'd4);
    start = 1'b1;
    tick(); start = 1'b0;
    #1 chk("resume_state", 64'(state_o), 64'd1);
    mc_done = 1'b1;
    #1 chk("stray_done", 64'({pc_enable, state_o}), 64'h9);
    tick(); mc_done = 1'b0;

    mc_start = 1'b1;
    tick(); mc_start = 1'b0; ex_branch_taken = 1'b1;
    #1 chk("mcw_branch_ignored", 64'(branch_taken), 64'd0);
    for (int i = 0; i < 254; i++) begin
      tick();
      ex_branch_taken = 1'b0;
    end
    chk("mcw_last_cycle", 64'(state_o), 64'd3);
    tick();
    chk("err_state", 64'(state_o), 64'd5);
    chk("err_flag", 64'(mc_timeout), 64'd1);
    chk("err_stalls", 64'(stall_cycles), 64'd265);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("err_sticky", 64'({mc_timeout, state_o}), 64'hD);

    #2 rst = 1'b1;
    #1;
    chk("async_rst", 64'({state_o, mc_timeout, pc_enable, ifid_flush}), 64'd1);
    chk("async_rst_cnt", 64'(stall_cycles), 64'd0);
    tick(); rst = 1'b0;
    tick();
    chk("post_rst_idle", 64'(state_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
